aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NROUNDS, default 10: number of cipher rounds after the initial key addition.
REQ-002 Parameter TIMEOUT, default 16: max cycles a stage enable may stay high without its finished input.
REQ-003 The block SHALL have these ports:
- clk  in  1  sole clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one block encryption; sampled only in IDLE or ERROR.
- abort  in  1  cancel the operation in progress.
- sbox_finished  in  1  SubBytes stage done.
- srows_finished  in  1  ShiftRows stage done.
- mcols_finished  in  1  MixColumns stage done.
- addkey_finished  in  1  AddRoundKey stage done.
- sbox_enable  out  1  SubBytes request.
- srows_enable  out  1  ShiftRows request.
- mcols_enable  out  1  MixColumns request.
- addkey_enable  out  1  AddRoundKey request.
- data_load  out  1  datapath captures the active stage's newdata into the state register.
- round_num  out  4  current round, 0..NROUNDS; also the key-schedule index.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  stage timeout latched.

Function
REQ-004 FSM states SHALL be IDLE, ADDKEY0, SUBBYTES, SHIFTROWS, MIXCOLS, ADDKEY, DONE and ERROR.
REQ-005 Exactly one stage enable SHALL be high in each stage state, and all enables SHALL be low in IDLE, DONE and ERROR:
- ADDKEY0 and ADDKEY drive addkey_enable.
- SUBBYTES drives sbox_enable.
- SHIFTROWS drives srows_enable.
- MIXCOLS drives mcols_enable.
REQ-006 Enables SHALL be Moore outputs: high from the first cycle in the state until the cycle the matching finished is sampled high, inclusive.
REQ-007 data_load SHALL equal (active enable AND matching finished), combinationally, in the same cycle.
REQ-008 Finished inputs of non-active stages SHALL be ignored.
REQ-009 Transitions SHALL occur on the cycle the active finished is high:
- IDLE --start--> ADDKEY0, round_num=0.
- ADDKEY0 -> SUBBYTES, round_num=1.
- SUBBYTES -> SHIFTROWS.
- SHIFTROWS -> MIXCOLS if round_num<NROUNDS, else ADDKEY.
- MIXCOLS -> ADDKEY.
- ADDKEY -> SUBBYTES with round_num+1 if round_num<NROUNDS, else DONE.
- DONE -> IDLE unconditionally after one cycle.
REQ-010 round_num SHALL increment only on the ADDKEY->SUBBYTES and ADDKEY0->SUBBYTES transitions, SHALL hold otherwise, and SHALL never exceed NROUNDS.
REQ-011 busy SHALL be high in ADDKEY0 through ADDKEY; done SHALL be high only in DONE; busy and done SHALL never both be high.
REQ-012 start while busy or in DONE SHALL be ignored.
REQ-013 Watchdog counter:
- Clears on every state entry.
- Increments each cycle a stage enable is high and its finished is low.
- On reaching TIMEOUT, the FSM SHALL go to ERROR on the next edge.
- A finished input arriving in the same cycle that the count reaches TIMEOUT wins; the normal transition is taken.
REQ-014 In ERROR, error SHALL be 1 and round_num SHALL hold. start SHALL go to ADDKEY0 with error cleared and round_num=0.
REQ-015 abort SHALL force IDLE on the next edge from any state, and SHALL cause no done or data_load (data_load is forced low while abort=1).
REQ-016 abort SHALL take priority over start and finished; abort in ERROR SHALL clear error.

Reset
REQ-017 While rst=1 at a clock edge, the block SHALL enter IDLE with all outputs 0, round_num=0 and watchdog=0.
REQ-018 rst SHALL take priority over abort and start, including mid-sequence.

Verification
REQ-019 All finished inputs tied high, start pulsed one cycle:
- busy high exactly 40 cycles (1 + 9×4 + 3).
- done pulse in cycle 41.
- data_load high 40 cycles.
- mcols_enable never high while round_num=10.
REQ-020 Every finished asserted 2 cycles after its enable rises:
- Each enable high exactly 3 cycles.
- round_num sequence 0,1..10.
- Total busy 120 cycles.
REQ-021 srows_finished held low in round 3:
- srows_enable high 16 cycles.
- ERROR entered next cycle; error=1; round_num=3.
- A later start restarts at round_num=0 with error=0.
REQ-022 abort asserted during MIXCOLS of round 5, with start held high the same cycle: IDLE next cycle, all outputs 0, no done pulse.
REQ-023 rst asserted during ADDKEY of round 7: all outputs 0 on the next edge. start pulsed again during busy: sequence unaffected, done pulse count stays 1.
REQ-024 Unrelated finished inputs toggled randomly throughout: state sequence and data_load identical to REQ-019.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: walks SubBytes/ShiftRows/MixColumns/AddRoundKey stage handshakes
// for NROUNDS rounds, with a per-stage watchdog, abort and a latched timeout error.
module aes_round_ctrl #(
  parameter int unsigned NROUNDS = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       sbox_finished,
  input  logic       srows_finished,
  input  logic       mcols_finished,
  input  logic       addkey_finished,
  output logic       sbox_enable,
  output logic       srows_enable,
  output logic       mcols_enable,
  output logic       addkey_enable,
  output logic       data_load,
  output logic [3:0] round_num,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LastRound = 4'(NROUNDS);
  localparam logic [WdogW-1:0] WdogLimit = WdogW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StAddKey0, StSubBytes, StShiftRows, StMixCols, StAddKey, StDone, StError
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             stage_en, stage_fin, timeout;

  always_comb begin
    sbox_enable   = (state_q == StSubBytes);
    srows_enable  = (state_q == StShiftRows);
    mcols_enable  = (state_q == StMixCols);
    addkey_enable = (state_q == StAddKey0) || (state_q == StAddKey);
    stage_en      = sbox_enable | srows_enable | mcols_enable | addkey_enable;
    // Only the finished input matching the active enable is ever observed.
    stage_fin     = (sbox_enable & sbox_finished) | (srows_enable & srows_finished) |
                    (mcols_enable & mcols_finished) | (addkey_enable & addkey_finished);
    data_load     = stage_fin & ~abort;
    // Fires in the cycle the count would reach TIMEOUT, so ERROR follows on the next edge.
    timeout       = stage_en & ~stage_fin & (wdog_q == WdogLimit);
    busy          = stage_en;
    done          = (state_q == StDone) & ~abort;
    error         = (state_q == StError);
    round_num     = round_q;
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    unique case (state_q)
      StIdle, StError: begin
        if (start) begin
          state_d = StAddKey0;
          round_d = '0;
        end
      end
      StAddKey0: begin
        if (stage_fin) begin
          state_d = StSubBytes;
          round_d = 4'd1;
        end
      end
      StSubBytes: if (stage_fin) state_d = StShiftRows;
      StShiftRows: begin
        if (stage_fin) state_d = (round_q < LastRound) ? StMixCols : StAddKey;
      end
      StMixCols: if (stage_fin) state_d = StAddKey;
      StAddKey: begin
        if (stage_fin) begin
          if (round_q < LastRound) begin
            state_d = StSubBytes;
            round_d = round_q + 4'd1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
    endcase
    if (timeout) state_d = StError;
    if (abort) begin
      state_d = StIdle;
      round_d = '0;
    end
  end

  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (stage_en && !stage_fin) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      round_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: drives stage handshakes from a small responder and
// checks cycle counts, round sequence, timeout, abort and reset behaviour.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       sbox_finished, srows_finished, mcols_finished, addkey_finished;
  logic       sbox_enable, srows_enable, mcols_enable, addkey_enable;
  logic       data_load, busy, done, error;
  logic [3:0] round_num;

  int checks = 0;
  int errors = 0;

  // Per-run observations filled by run_seq.
  int busy_cnt, dl_cnt, done_cnt, done_cyc, m10_cnt, runs, bad_runs;
  int srows3_cnt, srows3_last, err_cyc, inj_cyc;
  logic [3:0]  err_round;
  logic        dl_inj;
  logic [12:0] post_outs;
  int          rnd_q[$];
  logic [4:0]  trace[$];
  logic [4:0]  ref_trace[$];

  always #5 clk = ~clk;

  aes_round_ctrl #(.NROUNDS(10), .TIMEOUT(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .sbox_finished   (sbox_finished),
    .srows_finished  (srows_finished),
    .mcols_finished  (mcols_finished),
    .addkey_finished (addkey_finished),
    .sbox_enable     (sbox_enable),
    .srows_enable    (srows_enable),
    .mcols_enable    (mcols_enable),
    .addkey_enable   (addkey_enable),
    .data_load       (data_load),
    .round_num       (round_num),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  function automatic logic [12:0] outs();
    return {sbox_enable, srows_enable, mcols_enable, addkey_enable, data_load,
            round_num, busy, done, error};
  endfunction

  // mode 0: all finished high; 1: active finished 2 cycles after its enable rises;
  // 2: active high, others random; 3: like 0 but ShiftRows stalls in round 3.
  task automatic set_fin(input int mode, input int age);
    logic a, o;
    a = 1'b1;
    o = 1'b1;
    if (mode == 1) begin
      a = (age >= 2);
      o = 1'b0;
    end
    if (mode == 3 && srows_enable && round_num == 4'd3) a = 1'b0;
    sbox_finished   = sbox_enable   ? a : (mode == 2 ? 1'($urandom_range(0, 1)) : o);
    srows_finished  = srows_enable  ? a : (mode == 2 ? 1'($urandom_range(0, 1)) : o);
    mcols_finished  = mcols_enable  ? a : (mode == 2 ? 1'($urandom_range(0, 1)) : o);
    addkey_finished = addkey_enable ? a : (mode == 2 ? 1'($urandom_range(0, 1)) : o);
  endtask

  // inject 1: abort+start in MIXCOLS round 5; 2: rst in ADDKEY round 7; 3: start held while busy.
  task automatic run_seq(input int mode, input int inject, input int budget);
    logic [3:0] en, prev_en;
    int run_len, age;
    busy_cnt = 0; dl_cnt = 0; done_cnt = 0; done_cyc = -1; m10_cnt = 0;
    runs = 0; bad_runs = 0; srows3_cnt = 0; srows3_last = -1; err_cyc = -1;
    inj_cyc = -1; err_round = 4'hf; dl_inj = 1'b0; post_outs = '1;
    rnd_q.delete();
    trace.delete();
    prev_en = 4'b0;
    run_len = 0;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; rst = 1'b0;
    set_fin(0, 0);
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      en = {sbox_enable, srows_enable, mcols_enable, addkey_enable};
      if (en != prev_en) begin
        if (prev_en != 4'b0) begin
          runs++;
          if (run_len != 3) bad_runs++;
        end
        run_len = 0;
      end
      age = run_len;
      run_len++;
      prev_en = en;
      start = (inject == 3) ? busy : 1'b0;
      abort = 1'b0;
      rst = 1'b0;
      if (inject == 1 && inj_cyc < 0 && mcols_enable && round_num == 4'd5) begin
        abort = 1'b1; start = 1'b1; inj_cyc = k;
      end
      if (inject == 2 && inj_cyc < 0 && addkey_enable && round_num == 4'd7) begin
        rst = 1'b1; inj_cyc = k;
      end
      set_fin(mode, age);
      #1;
      if (k == inj_cyc) dl_inj = data_load;
      if (inj_cyc > 0 && k == inj_cyc + 1) post_outs = outs();
      if (busy) busy_cnt++;
      if (data_load) dl_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (mcols_enable && round_num == 4'd10) m10_cnt++;
      if (srows_enable && round_num == 4'd3) begin
        srows3_cnt++;
        srows3_last = k;
      end
      if (error && err_cyc < 0) begin
        err_cyc = k;
        err_round = round_num;
      end
      if (busy && (rnd_q.size() == 0 || rnd_q[$] != int'(round_num))) rnd_q.push_back(int'(round_num));
      trace.push_back({en, data_load});
      if ((done_cyc > 0 && k >= done_cyc + 2) || (err_cyc > 0 && k >= err_cyc + 1) ||
          (inj_cyc > 0 && k >= inj_cyc + 3)) break;
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    set_fin(0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outs() !== 13'h0) begin
      errors++;
      $display("FAIL reset_outs: got %h want 0", outs());
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (outs() !== 13'h0) begin
      errors++;
      $display("FAIL idle_outs: got %h want 0", outs());
    end
  endtask

  task automatic test_all_finished();
    run_seq(0, 0, 100);
    ref_trace = trace;
    checks++;
    if (busy_cnt != 40) begin errors++; $display("FAIL fast_busy: got %0d want 40", busy_cnt); end
    checks++;
    if (done_cyc != 41) begin errors++; $display("FAIL fast_done_cyc: got %0d want 41", done_cyc); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL fast_done_cnt: got %0d want 1", done_cnt); end
    checks++;
    if (dl_cnt != 40) begin errors++; $display("FAIL fast_dload: got %0d want 40", dl_cnt); end
    checks++;
    if (m10_cnt != 0) begin errors++; $display("FAIL fast_mcols_r10: got %0d want 0", m10_cnt); end
  endtask

  task automatic test_delayed();
    int bad_seq;
    run_seq(1, 0, 300);
    checks++;
    if (busy_cnt != 120) begin errors++; $display("FAIL slow_busy: got %0d want 120", busy_cnt); end
    checks++;
    if (runs != 40 || bad_runs != 0) begin
      errors++;
      $display("FAIL slow_enable_runs: got %0d runs %0d bad want 40 runs 0 bad", runs, bad_runs);
    end
    bad_seq = (rnd_q.size() == 11) ? 0 : 1;
    foreach (rnd_q[i]) if (rnd_q[i] != i) bad_seq++;
    checks++;
    if (bad_seq != 0) begin
      errors++;
      $display("FAIL slow_round_seq: got %0d entries %0d wrong want 0..10", rnd_q.size(), bad_seq);
    end
    checks++;
    if (done_cyc != 121) begin errors++; $display("FAIL slow_done_cyc: got %0d want 121", done_cyc); end
  endtask

  task automatic test_timeout();
    run_seq(3, 0, 300);
    checks++;
    if (srows3_cnt != 16) begin errors++; $display("FAIL to_srows_cycles: got %0d want 16", srows3_cnt); end
    checks++;
    if (err_cyc != srows3_last + 1 || srows3_last < 0) begin
      errors++;
      $display("FAIL to_error_cyc: got %0d want %0d", err_cyc, srows3_last + 1);
    end
    checks++;
    if (err_round !== 4'd3) begin errors++; $display("FAIL to_round: got %0d want 3", err_round); end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL to_done: got %0d want 0", done_cnt); end
    // Restart from ERROR.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    checks++;
    if ({addkey_enable, round_num, busy, error} !== 7'b1_0000_1_0) begin
      errors++;
      $display("FAIL to_restart: got %b want 1000010", {addkey_enable, round_num, busy, error});
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    // Second timeout, then abort+start in ERROR: abort must win and clear error.
    run_seq(3, 0, 300);
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (outs() !== 13'h0) begin
      errors++;
      $display("FAIL to_abort_err: got %h want 0", outs());
    end
  endtask

  task automatic test_abort();
    run_seq(0, 1, 100);
    checks++;
    if (dl_inj !== 1'b0 || inj_cyc < 0) begin
      errors++;
      $display("FAIL abort_dload: got %b at cyc %0d want 0", dl_inj, inj_cyc);
    end
    checks++;
    if (post_outs !== 13'h0) begin errors++; $display("FAIL abort_outs: got %h want 0", post_outs); end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_rst_mid();
    run_seq(0, 2, 100);
    checks++;
    if (post_outs !== 13'h0 || inj_cyc < 0) begin
      errors++;
      $display("FAIL rst_mid_outs: got %h want 0", post_outs);
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL rst_mid_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int diff;
    run_seq(0, 3, 100);
    diff = (trace.size() == ref_trace.size()) ? 0 : 1;
    foreach (trace[i]) if (i < ref_trace.size() && trace[i] !== ref_trace[i]) diff++;
    checks++;
    if (diff != 0) begin errors++; $display("FAIL b2b_trace: got %0d diffs want 0", diff); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_random_unrelated();
    int diff;
    run_seq(2, 0, 100);
    diff = (trace.size() == ref_trace.size()) ? 0 : 1;
    foreach (trace[i]) if (i < ref_trace.size() && trace[i] !== ref_trace[i]) diff++;
    checks++;
    if (diff != 0) begin errors++; $display("FAIL rand_trace: got %0d diffs want 0", diff); end
    checks++;
    if (done_cyc != 41) begin errors++; $display("FAIL rand_done_cyc: got %0d want 41", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_all_finished();
    test_delayed();
    test_timeout();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    test_random_unrelated();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
